// File: rtl/semiauto_pkg.sv
// Shared definitions for the semi-automatic navigation controller.
// Holds the nav_state encoding and the moving_state motion codes that
// the controller drives towards the motor and light drivers.
package semiauto_pkg;

  typedef enum logic [2:0] {
    NAV_CRUISE = 3'b000,
    NAV_WAIT   = 3'b001,
    NAV_TURN   = 3'b010,
    NAV_UTURN  = 3'b011,
    NAV_COOL   = 3'b100
  } nav_state_e;

  localparam logic [3:0] MOVE_STOP    = 4'b0000;
  localparam logic [3:0] MOVE_FORWARD = 4'b0001;
  localparam logic [3:0] MOVE_LEFT    = 4'b0100;
  localparam logic [3:0] MOVE_RIGHT   = 4'b1000;

endpackage

// File: rtl/semiauto_tick.sv
// Tick divider for the navigation controller.
// Counts 0..TICK_DIV-1 and flags the last count as a one-cycle tick.
// Ports:
//   sys_clk   - system clock
//   rst       - synchronous active-high reset
//   restart_i - forces the count back to 0 on the next edge
//   tick_o    - high for the one cycle the count equals TICK_DIV-1
module semiauto_tick #(
  parameter int TICK_DIV = 2000000
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic restart_i,
  output logic tick_o
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;

  if (TICK_DIV < 2) begin : g_chk_div
    $error("semiauto_tick: TICK_DIV must be >= 2");
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  always_comb begin
    div_d = div_q + 1'b1;
    if (restart_i || (div_q == DIV_LAST)) begin
      div_d = '0;
    end
  end

  // Decoded straight from the register, so the pulse is glitch-free and
  // is low while the divider is held in restart.
  assign tick_o = (div_q == DIV_LAST);

endmodule

// File: rtl/semiauto_nav.sv
// Semi-automatic navigation controller.
// Follows the lane, stops at debounced crossroads and executes the
// operator's straight / left / right / U-turn command with tick-exact
// durations.
// Ports:
//   sys_clk, rst            - clock, synchronous active-high reset
//   enable                  - low forces WAIT/STOP and clears all timing
//   detector                - line/obstacle detector inputs
//   turn_left, turn_right,
//   go_straight, go_back    - level-sensitive operator commands
//   nav_state               - current FSM state
//   moving_state            - motion code for the motor driver
//   *_light                 - indicator lights decoded from registered state
//   tick                    - divider tick, for observation
//
// state  | meaning
// CRUISE | lane following, debouncing crossroad on each tick
// WAIT   | stopped at a crossroad, waiting for an operator command
// TURN   | left or right turn for TURN_TICKS ticks
// UTURN  | right-hand U-turn for UTURN_TICKS ticks
// COOL   | forward with detection ignored for COOL_TICKS ticks
module semiauto_nav
  import semiauto_pkg::*;
#(
  parameter int                 DET_W       = 4,
  parameter logic [DET_W-1:0]   CROSS_MASK  = 4'b0111,
  parameter logic [DET_W-1:0]   CROSS_POL   = 4'b0001,
  parameter int                 TICK_DIV    = 2000000,
  parameter int                 DEB_TICKS   = 2,
  parameter int                 TURN_TICKS  = 200,
  parameter int                 UTURN_TICKS = 400,
  parameter int                 COOL_TICKS  = 50,
  parameter int                 CNT_W       = 11
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DET_W-1:0] detector,
  input  logic             turn_left,
  input  logic             turn_right,
  input  logic             go_straight,
  input  logic             go_back,
  output logic [2:0]       nav_state,
  output logic [3:0]       moving_state,
  output logic             move_forward_light,
  output logic             move_backward_light,
  output logic             turn_left_light,
  output logic             turn_right_light,
  output logic             tick
);

  localparam logic [CNT_W-1:0] DEB_N   = CNT_W'(DEB_TICKS);
  localparam logic [CNT_W-1:0] TURN_N  = CNT_W'(TURN_TICKS);
  localparam logic [CNT_W-1:0] UTURN_N = CNT_W'(UTURN_TICKS);
  localparam logic [CNT_W-1:0] COOL_N  = CNT_W'(COOL_TICKS);

  if (DEB_TICKS < 1)   begin : g_chk_deb   $error("DEB_TICKS must be >= 1");   end
  if (TURN_TICKS < 1)  begin : g_chk_turn  $error("TURN_TICKS must be >= 1");  end
  if (UTURN_TICKS < 1) begin : g_chk_uturn $error("UTURN_TICKS must be >= 1"); end
  if (COOL_TICKS < 1)  begin : g_chk_cool  $error("COOL_TICKS must be >= 1");  end
  if ((64'(DEB_TICKS) >> CNT_W) != 0 || (64'(TURN_TICKS) >> CNT_W) != 0 ||
      (64'(UTURN_TICKS) >> CNT_W) != 0 || (64'(COOL_TICKS) >> CNT_W) != 0)
  begin : g_chk_cnt_w
    $error("CNT_W too narrow for the configured tick counts");
  end

  nav_state_e       state_q, state_d;
  logic [3:0]       moving_q, moving_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] deb_q, deb_d, deb_inc;
  logic             dir_right_q, dir_right_d;
  logic             crossroad;
  logic             tick_w;
  logic             restart;

  // A bit votes for a crossroad when it is masked in and sits at its
  // polarity level; any single vote is enough.
  assign crossroad = |(CROSS_MASK & ~(detector ^ CROSS_POL));

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign deb_inc = (deb_q == '1) ? deb_q : deb_q + 1'b1;

  // Realigning the divider on every state change makes each timed state
  // last an exact multiple of TICK_DIV cycles.
  assign restart = ~enable | (state_d != state_q);

  semiauto_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .restart_i (restart),
    .tick_o    (tick_w)
  );

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= NAV_WAIT;
      moving_q    <= MOVE_STOP;
      cnt_q       <= '0;
      deb_q       <= '0;
      dir_right_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      moving_q    <= moving_d;
      cnt_q       <= cnt_d;
      deb_q       <= deb_d;
      dir_right_q <= dir_right_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    deb_d       = deb_q;
    dir_right_d = dir_right_q;
    if (!enable) begin
      state_d = NAV_WAIT;
      cnt_d   = '0;
      deb_d   = '0;
    end else begin
      unique case (state_q)
        NAV_CRUISE: begin
          if (tick_w) begin
            if (!crossroad) begin
              deb_d = '0;
            end else if (deb_inc == DEB_N) begin
              state_d = NAV_WAIT;
              deb_d   = '0;
            end else begin
              deb_d = deb_inc;
            end
          end
        end
        NAV_WAIT: begin
          if (go_straight) begin
            state_d = NAV_COOL;
          end else if (go_back) begin
            state_d = NAV_UTURN;
          end else if (turn_left && !turn_right) begin
            state_d     = NAV_TURN;
            dir_right_d = 1'b0;
          end else if (turn_right && !turn_left) begin
            state_d     = NAV_TURN;
            dir_right_d = 1'b1;
          end
        end
        NAV_TURN: begin
          if (tick_w) begin
            if (cnt_inc == TURN_N) state_d = NAV_WAIT;
            else                   cnt_d   = cnt_inc;
          end
        end
        NAV_UTURN: begin
          if (tick_w) begin
            if (cnt_inc == UTURN_N) state_d = NAV_WAIT;
            else                    cnt_d   = cnt_inc;
          end
        end
        NAV_COOL: begin
          if (tick_w) begin
            if (cnt_inc == COOL_N) begin
              state_d = NAV_CRUISE;
              deb_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        default: state_d = NAV_WAIT;
      endcase
      if (state_d != state_q) begin
        cnt_d = '0;
      end
    end
  end

  always_comb begin
    moving_d = MOVE_STOP;
    unique case (state_d)
      NAV_CRUISE, NAV_COOL: moving_d = MOVE_FORWARD;
      NAV_TURN:             moving_d = dir_right_d ? MOVE_RIGHT : MOVE_LEFT;
      NAV_UTURN:            moving_d = MOVE_RIGHT;
      default:              moving_d = MOVE_STOP;
    endcase
  end

  assign nav_state           = state_q;
  assign moving_state        = moving_q;
  assign tick                = tick_w;
  assign move_forward_light  = (moving_q == MOVE_FORWARD);
  assign turn_left_light     = (moving_q == MOVE_LEFT);
  assign turn_right_light    = (moving_q == MOVE_RIGHT) && (state_q != NAV_UTURN);
  assign move_backward_light = (state_q == NAV_UTURN);

endmodule

// File: tb/tb_semiauto_nav.sv
module tb_semiauto_nav;

  localparam int TICK_DIV    = 4;
  localparam int DEB_TICKS   = 2;
  localparam int TURN_TICKS  = 3;
  localparam int UTURN_TICKS = 6;
  localparam int COOL_TICKS  = 2;
  localparam logic [3:0] CMASK = 4'b0111;
  localparam logic [3:0] CPOL  = 4'b0001;

  localparam int S_CRUISE = 0, S_WAIT = 1, S_TURN = 2, S_UTURN = 3, S_COOL = 4;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] detector = 4'b0110;
  logic       turn_left = 1'b0, turn_right = 1'b0, go_straight = 1'b0, go_back = 1'b0;
  logic [2:0] nav_state;
  logic [3:0] moving_state;
  logic       move_forward_light, move_backward_light, turn_left_light, turn_right_light;
  logic       tick;

  int checks = 0;
  int errors = 0;

  // Reference model: state number, cycles since last divider restart,
  // consecutive crossroad ticks seen, turn direction.
  int m_state = S_WAIT;
  int m_phase = 0;
  int m_deb   = 0;
  bit m_dir_right = 1'b0;

  semiauto_nav #(
    .DET_W(4), .CROSS_MASK(CMASK), .CROSS_POL(CPOL), .TICK_DIV(TICK_DIV),
    .DEB_TICKS(DEB_TICKS), .TURN_TICKS(TURN_TICKS), .UTURN_TICKS(UTURN_TICKS),
    .COOL_TICKS(COOL_TICKS), .CNT_W(11)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .enable(enable), .detector(detector),
    .turn_left(turn_left), .turn_right(turn_right), .go_straight(go_straight),
    .go_back(go_back), .nav_state(nav_state), .moving_state(moving_state),
    .move_forward_light(move_forward_light), .move_backward_light(move_backward_light),
    .turn_left_light(turn_left_light), .turn_right_light(turn_right_light), .tick(tick)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic bit is_cross(input logic [3:0] d);
    logic [3:0] m;
    logic [3:0] p;
    m = CMASK;
    p = CPOL;
    for (int i = 0; i < 4; i++) begin
      if (m[i] && (d[i] == p[i])) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [3:0] rand_noncross();
    logic [3:0] d;
    d = {1'($urandom_range(0, 1)), 3'b110};
    return d;
  endfunction

  function automatic logic [3:0] rand_cross();
    logic [3:0] d;
    d = 4'($urandom);
    while (!is_cross(d)) d = 4'($urandom);
    return d;
  endfunction

  // Expected {nav_state, moving_state, fwd, back, left, right, tick}.
  function automatic logic [11:0] exp_vec();
    logic [3:0] mv;
    case (m_state)
      S_CRUISE, S_COOL: mv = 4'b0001;
      S_TURN:           mv = m_dir_right ? 4'b1000 : 4'b0100;
      S_UTURN:          mv = 4'b1000;
      default:          mv = 4'b0000;
    endcase
    return {3'(m_state), mv, mv == 4'b0001, m_state == S_UTURN, mv == 4'b0100,
            (mv == 4'b1000) && (m_state != S_UTURN),
            (m_phase % TICK_DIV) == TICK_DIV - 1};
  endfunction

  function automatic logic [11:0] obs_vec();
    return {nav_state, moving_state, move_forward_light, move_backward_light,
            turn_left_light, turn_right_light, tick};
  endfunction

  // Advances the model by one clock using the inputs as they sit before the edge.
  task automatic model_edge();
    int  ns;
    bit  tk;
    tk = (m_phase % TICK_DIV) == TICK_DIV - 1;
    if (rst || !enable) begin
      m_state = S_WAIT;
      m_phase = 0;
      m_deb   = 0;
    end else begin
      ns = m_state;
      case (m_state)
        S_CRUISE: if (tk) begin
          if (is_cross(detector)) begin
            m_deb++;
            if (m_deb >= DEB_TICKS) begin
              ns = S_WAIT;
              m_deb = 0;
            end
          end else begin
            m_deb = 0;
          end
        end
        S_WAIT: begin
          if (go_straight) ns = S_COOL;
          else if (go_back) ns = S_UTURN;
          else if (turn_left && !turn_right) begin ns = S_TURN; m_dir_right = 1'b0; end
          else if (turn_right && !turn_left) begin ns = S_TURN; m_dir_right = 1'b1; end
        end
        S_TURN:  if (m_phase + 1 == TURN_TICKS * TICK_DIV) ns = S_WAIT;
        S_UTURN: if (m_phase + 1 == UTURN_TICKS * TICK_DIV) ns = S_WAIT;
        S_COOL:  if (m_phase + 1 == COOL_TICKS * TICK_DIV) begin ns = S_CRUISE; m_deb = 0; end
        default: ns = S_WAIT;
      endcase
      if (ns != m_state) begin
        m_state = ns;
        m_phase = 0;
      end else begin
        m_phase++;
      end
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic go_wait();
    enable = 1'b0;
    cycle();
    enable = 1'b1;
    cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    cycle();
    cycle();
    checks++;
    if (obs_vec() !== 12'b001_0000_0000_0) begin
      errors++;
      $display("FAIL reset_values: got %b expected %b", obs_vec(), 12'b001_0000_0000_0);
    end
    rst = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL idle_wait[%0d]: got %b expected %b", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (nav_state !== 3'b001 || moving_state !== 4'b0000) begin
      errors++;
      $display("FAIL idle_wait_state: got nav=%b mv=%b expected nav=001 mv=0000", nav_state, moving_state);
    end
  endtask

  task automatic test_straight();
    int n;
    detector = rand_noncross();
    go_straight = 1'b1;
    cycle();
    go_straight = 1'b0;
    n = 0;
    while (nav_state === 3'b100 && n < 100) begin
      n++;
      checks++;
      if (move_forward_light !== 1'b1) begin
        errors++;
        $display("FAIL cool_fwd_light: got %b expected 1", move_forward_light);
      end
      cycle();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL cool_vec: got %b expected %b", obs_vec(), exp_vec());
      end
    end
    checks++;
    if (n != COOL_TICKS * TICK_DIV || nav_state !== 3'b000) begin
      errors++;
      $display("FAIL cool_length: got %0d cycles then nav=%b expected %0d then 000", n, nav_state, COOL_TICKS * TICK_DIV);
    end
    // crossroad held for two tick periods stops the car
    detector = 4'b0001;
    for (int i = 0; i < DEB_TICKS * TICK_DIV; i++) begin
      cycle();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL deb_stop_vec[%0d]: got %b expected %b", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (nav_state !== 3'b001 || moving_state !== 4'b0000) begin
      errors++;
      $display("FAIL deb_stop: got nav=%b mv=%b expected nav=001 mv=0000", nav_state, moving_state);
    end
    // single crossroad tick is filtered out
    detector = rand_noncross();
    go_straight = 1'b1;
    cycle();
    go_straight = 1'b0;
    for (int i = 1; i < COOL_TICKS * TICK_DIV; i++) cycle();
    detector = 4'b0001;
    for (int i = 0; i < TICK_DIV; i++) cycle();
    detector = rand_noncross();
    for (int i = 0; i < 3 * TICK_DIV; i++) begin
      cycle();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL deb_single_vec[%0d]: got %b expected %b", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (nav_state !== 3'b000 || moving_state !== 4'b0001) begin
      errors++;
      $display("FAIL deb_single: got nav=%b mv=%b expected nav=000 mv=0001", nav_state, moving_state);
    end
  endtask

  task automatic test_turn();
    int n;
    go_wait();
    turn_left = 1'b1;
    cycle();
    turn_left = 1'b0;
    n = 0;
    while (nav_state === 3'b010 && n < 100) begin
      n++;
      checks++;
      if (moving_state !== 4'b0100 || turn_left_light !== 1'b1) begin
        errors++;
        $display("FAIL turn_left_out: got mv=%b light=%b expected mv=0100 light=1", moving_state, turn_left_light);
      end
      cycle();
    end
    checks++;
    if (n != TURN_TICKS * TICK_DIV || nav_state !== 3'b001 || moving_state !== 4'b0000) begin
      errors++;
      $display("FAIL turn_left_length: got %0d cycles nav=%b mv=%b expected %0d nav=001 mv=0000", n, nav_state, moving_state, TURN_TICKS * TICK_DIV);
    end
    turn_left = 1'b1;
    turn_right = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++;
      if (nav_state !== 3'b001 || obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL both_turns_wait[%0d]: got %b expected %b", i, obs_vec(), exp_vec());
      end
    end
    turn_left = 1'b0;
    turn_right = 1'b0;
  endtask

  task automatic test_uturn();
    int n;
    go_back = 1'b1;
    turn_left = 1'b1;
    cycle();
    go_back = 1'b0;
    turn_left = 1'b0;
    n = 0;
    while (nav_state === 3'b011 && n < 100) begin
      n++;
      checks++;
      if (moving_state !== 4'b1000 || move_backward_light !== 1'b1 || turn_right_light !== 1'b0) begin
        errors++;
        $display("FAIL uturn_out: got mv=%b back=%b right=%b expected mv=1000 back=1 right=0", moving_state, move_backward_light, turn_right_light);
      end
      cycle();
    end
    checks++;
    if (n != UTURN_TICKS * TICK_DIV || nav_state !== 3'b001) begin
      errors++;
      $display("FAIL uturn_length: got %0d cycles nav=%b expected %0d nav=001", n, nav_state, UTURN_TICKS * TICK_DIV);
    end
  endtask

  task automatic test_enable_drop();
    int n;
    turn_left = 1'b1;
    cycle();
    turn_left = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    enable = 1'b0;
    cycle();
    checks++;
    if (obs_vec() !== 12'b001_0000_0000_0) begin
      errors++;
      $display("FAIL enable_drop: got %b expected %b", obs_vec(), 12'b001_0000_0000_0);
    end
    enable = 1'b1;
    turn_right = 1'b1;
    cycle();
    turn_right = 1'b0;
    n = 0;
    while (nav_state === 3'b010 && n < 100) begin
      n++;
      checks++;
      if (moving_state !== 4'b1000 || turn_right_light !== 1'b1) begin
        errors++;
        $display("FAIL turn_right_out: got mv=%b light=%b expected mv=1000 light=1", moving_state, turn_right_light);
      end
      cycle();
    end
    checks++;
    if (n != TURN_TICKS * TICK_DIV || nav_state !== 3'b001) begin
      errors++;
      $display("FAIL reenable_turn_length: got %0d cycles nav=%b expected %0d nav=001", n, nav_state, TURN_TICKS * TICK_DIV);
    end
  endtask

  task automatic test_rst_cool();
    detector = rand_noncross();
    go_straight = 1'b1;
    cycle();
    go_straight = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    rst = 1'b1;
    cycle();
    checks++;
    if (obs_vec() !== 12'b001_0000_0000_0) begin
      errors++;
      $display("FAIL rst_in_cool: got %b expected %b", obs_vec(), 12'b001_0000_0000_0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (tick !== (i == 2) || obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL tick_after_rst[%0d]: got %b expected %b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    logic [11:0] o, e;
    int bad;
    bad = 0;
    for (int i = 0; i < 4000; i++) begin
      rst         = ($urandom_range(0, 399) == 0);
      enable      = ($urandom_range(0, 79) != 0);
      go_straight = ($urandom_range(0, 29) == 0);
      go_back     = ($urandom_range(0, 39) == 0);
      turn_left   = ($urandom_range(0, 19) == 0);
      turn_right  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 5) == 0) detector = $urandom_range(0, 1) ? rand_cross() : rand_noncross();
      cycle();
      o = obs_vec();
      e = exp_vec();
      checks++;
      if (o !== e) begin
        errors++;
        bad++;
        if (bad <= 10) $display("FAIL random[%0d]: got %b expected %b", i, o, e);
      end
    end
    rst = 1'b0;
    enable = 1'b1;
    {go_straight, go_back, turn_left, turn_right} = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_straight();
    test_turn();
    test_uturn();
    test_enable_drop();
    test_rst_cool();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
